// File: rtl/regfile_2r1w_bypass.sv
// Register file with one synchronous write port and two registered read ports.
// A same-cycle write forwards to the readers, and one index is hardwired to zero.
module regfile_2r1w_bypass #(
  parameter  int WIDTH    = 64,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 31,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [WIDTH-1:0]  rd_data0,
  output logic [WIDTH-1:0]  rd_data1,
  output logic              rd_valid
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] rd_val0;
  logic [WIDTH-1:0] rd_val1;
  logic             wr_hit;

  // An address is live when it is neither the zero register nor out of range.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return (int'(a) != ZERO_REG) && (int'(a) < DEPTH);
  endfunction

  assign wr_hit = wr_en && addr_live(wr_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Bypass is gated by wr_hit, so a dropped write never forwards.
  always_comb begin
    rd_val0 = '0;
    rd_val1 = '0;
    if (addr_live(rd_addr0))
      rd_val0 = (wr_hit && (wr_addr == rd_addr0)) ? wr_data : regs[rd_addr0];
    if (addr_live(rd_addr1))
      rd_val1 = (wr_hit && (wr_addr == rd_addr1)) ? wr_data : regs[rd_addr1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data0 <= '0;
      rd_data1 <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data0 <= rd_val0;
        rd_data1 <= rd_val1;
      end
    end
  end

endmodule
